// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop unit and its per-loop slots.
// Macro HWLP_DUAL_ISSUE_EN (see riscv_hwloop_unit_nested) does not affect this package.
package riscv_hwloop_pkg;

    localparam int unsigned HWLP_PC_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } hwlp_state_e;

    typedef enum logic [1:0] {
        START = 2'd0,
        END   = 2'd1,
        COUNT = 2'd2
    } hwlp_regsel_e;

endpackage

// File: rtl/riscv_hwloop_slot.sv
// One hardware-loop register set: start/end/count, in-flight decrement tracking, state FSM and
// end-address match. HWLP_DUAL_ISSUE_EN adds a second comparator for the paired instruction.
module riscv_hwloop_slot
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned PW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_start_i,
    input  logic                 wr_end_i,
    input  logic                 wr_count_i,
    input  logic [HWLP_PC_W-1:0] wr_data_i,
    input  logic                 issue_i,
    input  logic                 retire_i,
    input  logic                 flush_i,
    input  logic [HWLP_PC_W-1:0] pc_i,
    input  logic                 pc_valid_i,
`ifdef HWLP_DUAL_ISSUE_EN
    input  logic [HWLP_PC_W-1:0] pc2_i,
    input  logic                 pc2_valid_i,
    output logic                 match2_o,
`endif
    output logic [HWLP_PC_W-1:0] start_o,
    output logic [HWLP_PC_W-1:0] end_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 active_o,
    output logic                 match_o,
    output logic                 full_o
);

    logic [HWLP_PC_W-1:0] start_q, start_d;
    logic [HWLP_PC_W-1:0] end_q, end_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PW-1:0]        pending_q, pending_d;
    hwlp_state_e          state_q, state_d;
    logic [CNT_W-1:0]     eff;
    logic                 eff_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= '0;
            end_q     <= '0;
            count_q   <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
        end else begin
            start_q   <= start_d;
            end_q     <= end_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    // A count write overrides any same-cycle retire or issue on this loop.
    always_comb begin
        start_d = wr_start_i ? wr_data_i : start_q;
        end_d   = wr_end_i ? wr_data_i : end_q;

        count_d = count_q;
        if (wr_count_i) begin
            count_d = wr_data_i[CNT_W-1:0];
        end else if (retire_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end

        pending_d = pending_q;
        if (wr_count_i || flush_i) begin
            pending_d = '0;
        end else if (issue_i && !retire_i) begin
            pending_d = pending_q + PW'(1);
        end else if (!issue_i && retire_i && pending_q != '0) begin
            pending_d = pending_q - PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr_count_i) begin
            state_d = (wr_data_i[CNT_W-1:0] == '0) ? IDLE : ARMED;
        end else if (retire_i && count_q == CNT_W'(1)) begin
            state_d = IDLE;
        end else if (issue_i && state_q == ARMED) begin
            state_d = ACTIVE;
        end
    end

    // Iterations still owed once every in-flight decrement lands; a jump needs at least two.
    always_comb begin
        eff      = count_q - CNT_W'(pending_q);
        eff_ok   = (state_q != IDLE) && (eff >= CNT_W'(2));
        active_o = (state_q != IDLE);
        match_o  = pc_valid_i && (pc_i == end_q) && eff_ok;
        full_o   = (pending_q == PW'(MAX_INFLIGHT));
`ifdef HWLP_DUAL_ISSUE_EN
        match2_o = pc2_valid_i && (pc2_i == end_q) && eff_ok;
`endif
    end

    assign start_o = start_q;
    assign end_o   = end_q;
    assign count_o = count_q;

endmodule

// File: rtl/riscv_hwloop_unit_nested.sv
// Nested hardware-loop unit: per-loop slots, lowest-index priority redirect, setup writes and CSR
// reads. Define HWLP_DUAL_ISSUE_EN to add the second-slot end compare and di_prevent_o.
module riscv_hwloop_unit_nested
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS       = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_INFLIGHT = 3,
    localparam int unsigned IDX_W       = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HWLP_PC_W-1:0] current_pc_i,
    input  logic                 pc_valid_i,
`ifdef HWLP_DUAL_ISSUE_EN
    input  logic                 current_is_compressed_i,
    input  logic                 i2_valid_i,
    output logic                 di_prevent_o,
`endif
    input  logic                 regwr_en_i,
    input  logic [1:0]           regwr_sel_i,
    input  logic [IDX_W-1:0]     regwr_idx_i,
    input  logic [HWLP_PC_W-1:0] regwr_data_i,
    input  logic [N_REGS-1:0]    dec_retire_i,
    input  logic                 flush_i,
    input  logic [1:0]           rd_sel_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [HWLP_PC_W-1:0] rd_data_o,
    output logic                 hwlp_jump_o,
    output logic [HWLP_PC_W-1:0] hwlp_targ_addr_o,
    output logic [N_REGS-1:0]    hwlp_dec_cnt_o,
    output logic                 hwlp_stall_o,
    output logic [N_REGS-1:0]    hwlp_active_o
);

    logic [N_REGS-1:0][HWLP_PC_W-1:0] slot_start;
    logic [N_REGS-1:0][HWLP_PC_W-1:0] slot_end;
    logic [N_REGS-1:0][CNT_W-1:0]     slot_count;
    logic [N_REGS-1:0]                slot_match;
    logic [N_REGS-1:0]                slot_full;
    logic [N_REGS-1:0]                wr_start, wr_end, wr_count;
    logic [N_REGS-1:0]                cand;
    logic [IDX_W-1:0]                 win;
    logic                             found;
    logic [HWLP_PC_W-1:0]             rd_data_q, rd_data_d;

`ifdef HWLP_DUAL_ISSUE_EN
    logic [N_REGS-1:0]    slot_match2;
    logic [HWLP_PC_W-1:0] pc2;
    logic                 pc2_valid;

    assign pc2       = current_pc_i + (current_is_compressed_i ? 32'd2 : 32'd4);
    assign pc2_valid = pc_valid_i && i2_valid_i;
`endif

    for (genvar j = 0; j < N_REGS; j++) begin : g_slot
        riscv_hwloop_slot #(
            .CNT_W        (CNT_W),
            .MAX_INFLIGHT (MAX_INFLIGHT)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .wr_start_i  (wr_start[j]),
            .wr_end_i    (wr_end[j]),
            .wr_count_i  (wr_count[j]),
            .wr_data_i   (regwr_data_i),
            .issue_i     (hwlp_dec_cnt_o[j]),
            .retire_i    (dec_retire_i[j]),
            .flush_i     (flush_i),
            .pc_i        (current_pc_i),
            .pc_valid_i  (pc_valid_i),
`ifdef HWLP_DUAL_ISSUE_EN
            .pc2_i       (pc2),
            .pc2_valid_i (pc2_valid),
            .match2_o    (slot_match2[j]),
`endif
            .start_o     (slot_start[j]),
            .end_o       (slot_end[j]),
            .count_o     (slot_count[j]),
            .active_o    (hwlp_active_o[j]),
            .match_o     (slot_match[j]),
            .full_o      (slot_full[j])
        );
    end

    always_comb begin
        wr_start = '0;
        wr_end   = '0;
        wr_count = '0;
        if (regwr_en_i && (32'(regwr_idx_i) < N_REGS)) begin
            case (regwr_sel_i)
                START:   wr_start[regwr_idx_i] = 1'b1;
                END:     wr_end[regwr_idx_i]   = 1'b1;
                COUNT:   wr_count[regwr_idx_i] = 1'b1;
                default: ;
            endcase
        end
    end

    // First-slot matches always outrank second-slot matches; within a slot, lowest index wins.
    always_comb begin
        cand = slot_match;
`ifdef HWLP_DUAL_ISSUE_EN
        if (slot_match == '0) begin
            cand = slot_match2;
        end
`endif
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < N_REGS; j++) begin
            if (cand[j] && !found) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    // A saturated winner holds ID rather than letting a lower-priority loop take the redirect.
    always_comb begin
        hwlp_jump_o      = found && !slot_full[win];
        hwlp_stall_o     = found && slot_full[win];
        hwlp_targ_addr_o = hwlp_jump_o ? slot_start[win] : '0;
        hwlp_dec_cnt_o   = '0;
        if (hwlp_jump_o) begin
            hwlp_dec_cnt_o[win] = 1'b1;
        end
    end

`ifdef HWLP_DUAL_ISSUE_EN
    assign di_prevent_o = |slot_match;
`endif

    always_comb begin
        rd_data_d = '0;
        if (32'(rd_idx_i) < N_REGS) begin
            case (rd_sel_i)
                START:   rd_data_d = slot_start[rd_idx_i];
                END:     rd_data_d = slot_end[rd_idx_i];
                COUNT:   rd_data_d = HWLP_PC_W'(slot_count[rd_idx_i]);
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
